// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic array sequencer
// Purpose: controller state encoding, default array geometry and the drain-length helper.
// Ports: none (package).
package systolic_pkg;

    localparam int ARRAY_N = 2;
    localparam int DATA_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Cycles needed after the last vector for the skew, array and de-skew to empty.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - host/array signal bundle for systolic_ctrl
// Purpose: groups job control, input stream, array control and result stream signals.
// Ports: start, num_vecs, busy, done, in_valid/in_ready/in_data, arr_load_w/arr_w_row/arr_w_data,
//        arr_en/arr_left/arr_res, out_valid/out_data; perf_cycles/perf_bubbles when
//        SYSTOLIC_CTRL_PERF_EN is defined. Modport slave = controller, master = host and array side.
interface systolic_ctrl_if #(
    parameter int N      = systolic_pkg::ARRAY_N,
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int CNT_W  = 8
);
    logic                   start;
    logic [CNT_W-1:0]       num_vecs;
    logic                   busy;
    logic                   done;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*DATA_W-1:0]    in_data;
    logic                   arr_load_w;
    logic [$clog2(N)-1:0]   arr_w_row;
    logic [N*DATA_W-1:0]    arr_w_data;
    logic                   arr_en;
    logic [N*DATA_W-1:0]    arr_left;
    logic [N*DATA_W-1:0]    arr_res;
    logic                   out_valid;
    logic [N*DATA_W-1:0]    out_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]            perf_cycles;
    logic [CNT_W-1:0]       perf_bubbles;

    modport slave (
        input  start, num_vecs, in_valid, in_data, arr_res,
        output busy, done, in_ready, arr_load_w, arr_w_row, arr_w_data,
               arr_en, arr_left, out_valid, out_data, perf_cycles, perf_bubbles
    );
    modport master (
        output start, num_vecs, in_valid, in_data, arr_res,
        input  busy, done, in_ready, arr_load_w, arr_w_row, arr_w_data,
               arr_en, arr_left, out_valid, out_data, perf_cycles, perf_bubbles
    );
`else
    modport slave (
        input  start, num_vecs, in_valid, in_data, arr_res,
        output busy, done, in_ready, arr_load_w, arr_w_row, arr_w_data,
               arr_en, arr_left, out_valid, out_data
    );
    modport master (
        output start, num_vecs, in_valid, in_data, arr_res,
        input  busy, done, in_ready, arr_load_w, arr_w_row, arr_w_data,
               arr_en, arr_left, out_valid, out_data
    );
`endif
endinterface

// File: rtl/systolic_skew.sv
// rtl/systolic_skew.sv - per-lane register delay line
// Purpose: delays lane i by i registers (ascending) or N-1-i registers (descending).
// Ports: clk, reset (async, active-high), i_data (N lanes in), o_data (N lanes out).
module systolic_skew #(
    parameter int N          = 2,
    parameter int DATA_W     = 32,
    parameter bit DESCENDING = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N*DATA_W-1:0] i_data,
    output logic [N*DATA_W-1:0] o_data
);
    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int D = DESCENDING ? (N - 1 - g) : g;
        if (D == 0) begin : g_pass
            assign o_data[g*DATA_W +: DATA_W] = i_data[g*DATA_W +: DATA_W];
        end else begin : g_dly
            logic [DATA_W-1:0] r_dly [D];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) r_dly[k] <= '0;
                end else begin
                    r_dly[0] <= i_data[g*DATA_W +: DATA_W];
                    for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
                end
            end
            assign o_data[g*DATA_W +: DATA_W] = r_dly[D-1];
        end
    end
endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for an NxN weight-stationary systolic array
// Purpose: loads N weight rows, streams K skewed input vectors, drains the array and
//          de-skews column results into single-beat result vectors.
// Ports: clk, reset (async, active-high), bus (systolic_ctrl_if.slave).
// Optional: SYSTOLIC_CTRL_PERF_EN adds perf_cycles and perf_bubbles counters.
module systolic_ctrl #(
    parameter int N      = systolic_pkg::ARRAY_N,
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    systolic_ctrl_if.slave  bus
);
    import systolic_pkg::*;

    localparam int ROW_W     = $clog2(N);
    localparam int DRAIN_CYC = drain_len(N);
    localparam int DRN_W     = $clog2(DRAIN_CYC + 1);
    localparam int VW        = N * DATA_W;

    ctrl_state_t          r_state;
    ctrl_state_t          w_next;
    logic [CNT_W-1:0]     r_num;
    logic [CNT_W-1:0]     r_vec;
    logic [ROW_W-1:0]     r_row;
    logic [DRN_W-1:0]     r_drain;
    logic [DRAIN_CYC-1:0] r_vpipe;
    logic                 w_beat;
    logic                 w_load;
    logic                 w_push;
    logic [VW-1:0]        w_push_data;
    logic [VW-1:0]        w_deskew;

    // in_ready is a pure decode of the state register, never of in_valid.
    assign bus.in_ready   = (r_state == LOAD_W) || (r_state == STREAM);
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.arr_en     = (r_state == STREAM) || (r_state == DRAIN);
    assign w_beat         = bus.in_valid && bus.in_ready;
    assign w_load         = w_beat && (r_state == LOAD_W);
    assign w_push         = w_beat && (r_state == STREAM);
    assign bus.arr_load_w = w_load;
    assign bus.arr_w_row  = w_load ? r_row : '0;
    assign bus.arr_w_data = w_load ? bus.in_data : '0;
    // Non-accepted cycles inject zeros so bubbles and drain never pollute results.
    assign w_push_data    = w_push ? bus.in_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_vec   <= '0;
            r_row   <= '0;
            r_drain <= '0;
            r_vpipe <= '0;
        end else begin
            r_state <= w_next;
            r_vpipe <= {r_vpipe[DRAIN_CYC-2:0], w_push};
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_num   <= bus.num_vecs;
                        r_row   <= '0;
                        r_vec   <= '0;
                        r_drain <= '0;
                    end
                end
                LOAD_W:  if (w_beat) r_row <= r_row + ROW_W'(1);
                STREAM:  if (w_beat) r_vec <= r_vec + CNT_W'(1);
                DRAIN:   r_drain <= r_drain + DRN_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus.start) w_next = LOAD_W;
            LOAD_W: begin
                if (w_beat && (r_row == ROW_W'(N - 1)))
                    w_next = (r_num == '0) ? DONE : STREAM;
            end
            // r_num >= 1 here, so r_num-1 cannot underflow and r_vec never wraps.
            STREAM: if (w_beat && (r_vec == r_num - CNT_W'(1))) w_next = DRAIN;
            DRAIN:  if (r_drain == DRN_W'(DRAIN_CYC - 1)) w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    systolic_skew #(.N(N), .DATA_W(DATA_W), .DESCENDING(1'b0)) u_skew (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_push_data),
        .o_data (bus.arr_left)
    );

    systolic_skew #(.N(N), .DATA_W(DATA_W), .DESCENDING(1'b1)) u_deskew (
        .clk    (clk),
        .reset  (reset),
        .i_data (bus.arr_res),
        .o_data (w_deskew)
    );

    assign bus.out_valid = r_vpipe[DRAIN_CYC-1];
    assign bus.out_data  = bus.out_valid ? w_deskew : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]      r_perf_cycles;
    logic [CNT_W-1:0] r_perf_bubbles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cycles  <= '0;
            r_perf_bubbles <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_perf_cycles  <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (r_state != IDLE) r_perf_cycles <= r_perf_cycles + 32'd1;
            if ((r_state == STREAM) && !bus.in_valid && (r_perf_bubbles != '1))
                r_perf_bubbles <= r_perf_bubbles + CNT_W'(1);
        end
    end

    assign bus.perf_cycles  = r_perf_cycles;
    assign bus.perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard testbench for systolic_ctrl with a behavioural 2x2 array
module tb_systolic_ctrl;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   out_cnt, done_cnt, en_cnt, load_cnt, last_load_cyc;
    bit   lag_en = 1'b0;
    logic [DW-1:0] prev_l0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ctrl_if #(.N(N), .DATA_W(DW), .CNT_W(CW)) bus ();

    systolic_ctrl #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural weight-stationary array: inputs move right, partial sums move down.
    logic [DW-1:0] w_mem [N][N];
    logic [DW-1:0] a_r   [N][N];
    logic [DW-1:0] p_r   [N][N];
    logic [DW-1:0] x_in;
    logic [DW-1:0] p_in;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    w_mem[i][j] <= '0;
                    a_r[i][j]   <= '0;
                    p_r[i][j]   <= '0;
                end
        end else begin
            if (bus.arr_load_w)
                for (int j = 0; j < N; j++) w_mem[bus.arr_w_row][j] <= bus.arr_w_data[j*DW +: DW];
            if (bus.arr_en)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        if (j == 0) x_in = bus.arr_left[i*DW +: DW];
                        else        x_in = a_r[i][j-1];
                        if (i == 0) p_in = '0;
                        else        p_in = p_r[i-1][j];
                        a_r[i][j] <= x_in;
                        p_r[i][j] <= p_in + w_mem[i][j] * x_in;
                    end
        end
    end

    assign bus.arr_res = {p_r[N-1][1], p_r[N-1][0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] vec(input int a, input int b);
        return {32'(b), 32'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_cnt = 0; done_cnt = 0; en_cnt = 0; load_cnt = 0; last_load_cyc = -1;
    endtask

    task automatic start_job(input int k);
        bus.num_vecs = CW'(k);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // Offers one beat; on acceptance a stream vector queues its expected result at accept+3.
    task automatic send(input logic [63:0] data, input bit is_vec, input logic [63:0] expd);
        exp_t e;
        bit   ok = 1'b0;
        int   waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                if (is_vec) begin
                    e.data = expd;
                    e.cyc  = cyc + 3;
                    exp_q.push_back(e);
                end
            end
            tick();
            waited++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic bubble();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic load_weights();
        send(vec(1, 2), 1'b0, '0);
        send(vec(3, 4), 1'b0, '0);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n = 0;
        dcyc = -1;
        while (n < budget && dcyc < 0) begin
            @(negedge clk);
            if (bus.done) dcyc = cyc;
            n++;
        end
        tick();
        chk("done_seen", 64'(dcyc >= 0), 64'd1);
    endtask

    task automatic run_basic(input string tag);
        int d;
        clear_mon();
        start_job(1);
        chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        load_weights();
        send(vec(5, 6), 1'b1, vec(23, 34));
        wait_done(40, d);
        chk({tag, "_loads"}, 64'(load_cnt), 64'd2);
        chk({tag, "_outs"}, 64'(out_cnt), 64'd1);
        chk({tag, "_dones"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever a result beat appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=no_beat (t=%0t)", bus.out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", bus.out_data, mon_e.data);
                    chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (bus.done) done_cnt++;
            if (bus.arr_en) en_cnt++;
            if (bus.arr_load_w) begin
                chk("w_row", 64'(bus.arr_w_row), 64'(load_cnt % N));
                chk("w_data", bus.arr_w_data, bus.in_data);
                load_cnt++;
                last_load_cyc = cyc;
            end
            if (lag_en && bus.arr_en) begin
                chk("lane1_lag", 64'(bus.arr_left[2*DW-1:DW]), 64'(prev_l0));
                prev_l0 = bus.arr_left[DW-1:0];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int d;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.num_vecs = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clear_mon();
        repeat (3) tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_load_w", 64'(bus.arr_load_w), 64'd0);
        chk("rst_arr_en", 64'(bus.arr_en), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_arr_left", bus.arr_left, 64'd0);
        chk("rst_w_data", bus.arr_w_data, 64'd0);
        reset = 1'b0;
        tick();

        // 1: basic job
        run_basic("t1");

        // 2: back-to-back vectors with lane skew observation
        clear_mon();
        prev_l0 = '0;
        lag_en  = 1'b1;
        start_job(4);
        load_weights();
        for (int k = 1; k <= 4; k++) send(vec(k, k), 1'b1, vec(4 * k, 6 * k));
        wait_done(40, d);
        lag_en = 1'b0;
        chk("t2_outs", 64'(out_cnt), 64'd4);
        chk("t2_dones", 64'(done_cnt), 64'd1);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 3: bubbles between vectors
        clear_mon();
        start_job(2);
        load_weights();
        send(vec(1, 0), 1'b1, vec(1, 2));
        bubble();
        bubble();
        send(vec(0, 1), 1'b1, vec(3, 4));
        wait_done(40, d);
        chk("t3_outs", 64'(out_cnt), 64'd2);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("t3_perf_bubbles", 64'(bus.perf_bubbles), 64'd2);
        chk("t3_perf_cycles", 64'(bus.perf_cycles), 64'd10);
`endif

        // 4: zero-length job skips STREAM and DRAIN
        clear_mon();
        start_job(0);
        load_weights();
        wait_done(20, d);
        chk("t4_done_after_load", 64'(d), 64'(last_load_cyc + 1));
        chk("t4_arr_en", 64'(en_cnt), 64'd0);
        chk("t4_outs", 64'(out_cnt), 64'd0);
        chk("t4_loads", 64'(load_cnt), 64'd2);

        // 5: start held high, num_vecs changed after latching
        clear_mon();
        bus.num_vecs = CW'(1);
        bus.start    = 1'b1;
        tick();
        bus.num_vecs = CW'(0);
        load_weights();
        send(vec(5, 6), 1'b1, vec(23, 34));
        wait_done(40, d);
        chk("t5_idle_between", 64'(bus.busy), 64'd0);
        chk("t5_first_outs", 64'(out_cnt), 64'd1);
        chk("t5_first_dones", 64'(done_cnt), 64'd1);
        tick();
        chk("t5_second_start", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        load_weights();
        wait_done(20, d);
        chk("t5_total_dones", 64'(done_cnt), 64'd2);
        chk("t5_total_outs", 64'(out_cnt), 64'd1);

        // 6: reset mid-job discards partial results
        clear_mon();
        start_job(3);
        load_weights();
        send(vec(1, 2), 1'b1, vec(7, 10));
        reset = 1'b1;
        #1;
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        run_basic("t6");

        chk("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the NxN weight-stationary systolic PE array.
- Runs a job in order:
  - loads N weight rows into the array;
  - streams K input vectors into the array's left edge, skewing lane i by i cycles;
  - drains the array;
  - de-skews column results so each result vector leaves as one valid beat.
- Sits between the host/DMA stream and the PE array; owns the array's load and enable controls.

Parameters:
- N, 2, array dimension (rows = columns = lanes).
- DATA_W, 32, width of one lane element.
- CNT_W, 8, width of the vector-count field.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- num_vecs  in  CNT_W  K, the number of input vectors in the job; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input stream ready.
- in_data  in  N*DATA_W  weight row (LOAD_W) or input vector (STREAM); lane i = bits [i*DATA_W +: DATA_W].
- arr_load_w  out  1  array weight-load strobe.
- arr_w_row  out  $clog2(N)  row index being loaded.
- arr_w_data  out  N*DATA_W  weight row to array.
- arr_en  out  1  array advance enable.
- arr_left  out  N*DATA_W  skewed left-edge lanes to array.
- arr_res  in  N*DATA_W  bottom-edge column results from array.
- out_valid  out  1  de-skewed result vector valid.
- out_data  out  N*DATA_W  de-skewed result vector.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = IDLE; all counters, skew/de-skew registers and valid pipe = 0.
  - busy, done, in_ready, arr_load_w, arr_en, out_valid = 0; all data outputs = 0.
- State machine: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches num_vecs and clears row/vector counters.
  - Next cycle is LOAD_W.
- LOAD_W:
  - in_ready=1.
  - Each beat with in_valid&in_ready drives arr_load_w=1 and arr_w_row=row counter, with arr_w_data=in_data in the same cycle (combinational passthrough).
  - After the Nth accepted row: go to STREAM if K>0, else to DONE. DRAIN is skipped when K=0.
- STREAM:
  - in_ready=1 and arr_en=1 every cycle; the array never stalls.
  - An accepted beat pushes in_data with valid bit 1 into the skew network.
  - A cycle without in_valid pushes zeros with valid bit 0 (a bubble).
  - After the Kth accepted vector, go to DRAIN.
- Skew: lane i passes through i registers; lane 0 is unregistered.
- DRAIN:
  - in_ready=0, arr_en=1, zeros injected, for exactly 2N-1 cycles; then DONE.
- DONE: done=1 for one cycle; busy stays 1 in DONE; next state IDLE.
- De-skew and result timing:
  - Column j from the array is delayed by N-1-j registers.
  - A 2N-1-deep valid shift register tracks the pushed valid bits.
  - Result for a vector accepted at cycle t appears with out_valid=1 at cycle t+2N-1.
  - Bubbles produce no out_valid.
  - All results have left before done is asserted.
- in_ready is registered from state only; it never depends on in_valid.
- Boundary rules:
  - start in any non-IDLE state: ignored.
  - in_valid while in_ready=0: data not consumed.
  - num_vecs changes after latching: no effect on the running job.
  - reset mid-job: immediate return to the reset values; partial results are discarded with no out_valid.
  - K=2^CNT_W-1: counters must not wrap.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- Defined:
  - adds outputs perf_cycles (32-bit) and perf_bubbles (CNT_W-bit).
  - Both clear on an accepted start.
  - perf_cycles counts every busy cycle.
  - perf_bubbles counts STREAM cycles with no accepted vector; saturates at max.
  - Both hold their values in IDLE.
- Undefined: the ports and the logic are absent.

Decomposition:
- Shared package systolic_pkg:
  - state enum ctrl_state_t (IDLE, LOAD_W, STREAM, DRAIN, DONE);
  - default constants ARRAY_N and DATA_W;
  - localparam function for drain length 2N-1.
- One sub-module: systolic_skew, a parameterised per-lane delay line (lane i delayed by DELAY(i) registers, selected ascending or descending). It is instantiated twice: skew (i) and de-skew (N-1-j).

Test Plan (N=2, DATA_W=32):
1. Basic job:
   - Stimulus: reset, then start with K=1; weight rows {1,2},{3,4}; one vector {5,6}.
   - Response: arr_load_w pulses with rows 0 and 1; out_valid exactly once, 3 cycles after the vector is accepted, with out_data = array result for that vector; then done pulses once and busy drops.
2. Back-to-back vectors:
   - Stimulus: K=4 vectors {1,1},{2,2},{3,3},{4,4} on consecutive cycles.
   - Response: 4 consecutive out_valid beats; arr_left lane1 lags lane0 by exactly 1 cycle.
3. Bubbles:
   - Stimulus: K=2, in_valid toggled 1,0,0,1.
   - Response: out_valid only at accept+3 for each vector; perf_bubbles=2 when SYSTOLIC_CTRL_PERF_EN is defined.
4. Zero-length job:
   - Stimulus: K=0.
   - Response: 2 weight beats, then done; no DRAIN; arr_en never asserted; out_valid never asserted.
5. Start while busy:
   - Stimulus: start held high throughout the job, with num_vecs changed mid-job.
   - Response: exactly one job runs with the original K; a second job starts only after returning to IDLE.
6. Reset mid-job:
   - Stimulus: assert reset in STREAM after 1 of 3 vectors.
   - Response: immediately busy=0, in_ready=0 and out_valid=0; no done pulse; the next job runs cleanly.
